framed_output_serializer: RTL and testbench
===========================================

// Module: framed_output_serializer
// PURPOSE
//   Buffered, framed serial output port that sits directly downstream of the control unit.
//   It replaces the raw shift-register output path on the processor's output pin.
//   Each output_data word strobed by output_enable is queued in a small FIFO.
//   Each queued word is sent as an idle-high frame: start bit, DATA_WIDTH data bits LSB first, stop bit.
//   Status flags let the control unit or bench see backpressure and dropped words.
// PARAMETERS
//   DATA_WIDTH     8  width of each output word / data bits per frame
//   FIFO_DEPTH     4  queued words; power of two, >= 2
//   CLKS_PER_BIT   4  clk cycles each serial bit is held; >= 1
// PORTS
//   clk         in   1           single clock, all state updates on rising edge
//   reset       in   1           synchronous, active-high
//   data_in     in   DATA_WIDTH  word to transmit (from control output_data)
//   wr_enable   in   1           write strobe, 1 cycle per word (from control output_enable)
//   serial_out  out  1           framed serial line, idles high
//   full        out  1           FIFO holds FIFO_DEPTH words; registered
//   busy        out  1           frame in progress or FIFO non-empty
//   overflow    out  1           1-cycle pulse when a write is dropped
// BEHAVIOUR
//   Reset (synchronous, active-high; one clock; takes priority over everything)
//   - Outputs after the edge: serial_out=1, full=0, busy=0, overflow=0.
//   - FIFO pointers and count are cleared and the FSM returns to IDLE.
//   - Reset mid-frame aborts the frame; the partial word is lost and the line is high from the next cycle.
//   FIFO
//   - A write is accepted when wr_enable=1 and count<FIFO_DEPTH.
//   - full=(count==FIFO_DEPTH) is evaluated on the registered count.
//   - A write while full is dropped, even if the FSM pops in the same cycle; overflow=1 for one cycle.
//   - A write and a pop in the same cycle leave count unchanged.
//   - Read and write pointers wrap modulo FIFO_DEPTH.
//   FSM states: IDLE, START, DATA, STOP
//   - A bit counter counts 0..CLKS_PER_BIT-1; an index counts 0..DATA_WIDTH-1.
//   - IDLE: serial_out=1. If count!=0, pop the head word into the shift register, go to START, and drive serial_out=0.
//   - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
//   - DATA: each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit DATA_WIDTH-1, go to STOP and drive 1.
//   - STOP: hold 1 for CLKS_PER_BIT cycles.
//     - If count!=0 at the last stop cycle: pop and go directly to START. No idle gap between frames.
//     - Otherwise go to IDLE.
//   Timing
//   - serial_out is registered.
//   - wr_enable in cycle k into an empty, IDLE block: the word is stored at the end of k, popped at the end of k+1, and serial_out=0 from cycle k+2.
//   - Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
//   - busy = (state!=IDLE) | (count!=0).
//   - busy falls in the cycle after the last stop-bit cycle of the last frame.
//   Invariants
//   - data_in is sampled only at accepted writes; later changes do not affect queued words.
//   - No X on any output after reset.
// TESTING  (DATA_WIDTH=8, FIFO_DEPTH=4, CLKS_PER_BIT=4)
//   - Reset, then idle 20 cycles -> serial_out=1, busy=0, full=0, overflow=0 throughout.
//   - Write 0xA5 in cycle k -> serial_out from k+2 is 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; busy=0 at k+42.
//   - Write 0x01, 0x80, 0xFF on consecutive cycles -> three back-to-back 40-cycle frames, no idle gap, LSB first.
//   - Write 6 words on consecutive cycles k..k+5 -> full=1 after edge k+4; 6th word dropped; overflow pulses in cycle k+5 only; exactly 5 frames sent, in order.
//   - Assert reset during DATA bit 3 of a frame with 2 words queued -> serial_out=1, busy=0, full=0 next cycle; no further frames.
//   - Write while full in the same cycle as the STOP->START pop -> write dropped, overflow=1, count drops by one.

Source files
------------

// File: rtl/framed_output_serializer.sv
// Buffered serial output port: a small FIFO of output words feeding an idle-high framer
// (start bit, DATA_WIDTH data bits LSB first, stop bit), with full/busy/overflow status.
module framed_output_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_enable,
    output logic                  serial_out,
    output logic                  full,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_serial;
    logic                  r_full;
    logic                  r_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_shift_en;
    logic                  w_serial_next;
    logic                  w_nonempty;
    logic                  w_bit_done;
    logic                  w_last_idx;
    logic [DATA_WIDTH-1:0] w_shift_nx;
    logic [CNT_W-1:0]      w_count_next;

    // A write while full is dropped even when a pop happens in the same cycle.
    assign w_push     = wr_enable & (r_count != CNT_FULL);
    assign w_nonempty = (r_count != CNT_ZERO);
    assign w_bit_done = (r_bit_cnt == BIT_LAST);
    assign w_last_idx = (r_idx == IDX_LAST);
    assign w_shift_nx = r_shift >> 1;

    assign serial_out = r_serial;
    assign full       = r_full;
    assign busy       = r_busy;
    assign overflow   = wr_enable & r_full & ~reset;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_next_state = S_START;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_done && w_last_idx) begin
                    w_next_state = S_STOP;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_STOP: begin
                if (w_bit_done && w_nonempty) begin
                    w_next_state = S_START;
                end else if (w_bit_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_STOP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM outputs: FIFO pop, shift strobe and the next registered line level
    always_comb begin
        w_pop         = 1'b0;
        w_shift_en    = 1'b0;
        w_serial_next = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_pop         = w_nonempty;
                w_serial_next = ~w_nonempty;
            end
            S_START: begin
                if (w_bit_done) begin
                    w_serial_next = r_shift[0];
                end else begin
                    w_serial_next = 1'b0;
                end
            end
            S_DATA: begin
                if (w_bit_done && w_last_idx) begin
                    w_serial_next = 1'b1;
                end else if (w_bit_done) begin
                    w_shift_en    = 1'b1;
                    w_serial_next = w_shift_nx[0];
                end else begin
                    w_serial_next = r_shift[0];
                end
            end
            S_STOP: begin
                // Pop on the last stop cycle so the next start bit follows with no gap.
                if (w_bit_done) begin
                    w_pop         = w_nonempty;
                    w_serial_next = ~w_nonempty;
                end else begin
                    w_serial_next = 1'b1;
                end
            end
            default: begin
                w_pop         = 1'b0;
                w_serial_next = 1'b1;
            end
        endcase
    end

    // Occupancy after this cycle's accepted write and pop
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= CNT_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Bit-period counter, data index and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= {BIT_W{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_shift   <= {DATA_WIDTH{1'b0}};
        end else begin
            if (r_state == S_IDLE || w_bit_done) begin
                r_bit_cnt <= {BIT_W{1'b0}};
            end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (r_state != S_DATA) begin
                r_idx <= {IDX_W{1'b0}};
            end else if (w_bit_done) begin
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_idx <= r_idx;
            end
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if (w_shift_en) begin
                r_shift <= w_shift_nx;
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    // Registered status outputs and serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            r_serial <= 1'b1;
            r_full   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_serial <= w_serial_next;
            r_full   <= (w_count_next == CNT_FULL);
            r_busy   <= (w_next_state != S_IDLE) | (w_count_next != CNT_ZERO);
        end
    end

endmodule

// File: tb/tb_framed_output_serializer.sv
// Scoreboard bench: a schedule-based reference model predicts every output each cycle,
// and a separate frame receiver decodes the serial line and checks words in order.
module tb_framed_output_serializer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          wr_enable = 1'b0;
    logic          serial_out, full, busy, overflow;

    framed_output_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .wr_enable(wr_enable),
        .serial_out(serial_out), .full(full), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference schedule: each accepted word gets a frame start cycle.
    int            m_acc[$];
    int            m_start[$];
    logic [DW-1:0] m_word[$];
    logic [DW-1:0] sb_q[$];
    int            t_free = 0;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    logic          exp_serial, exp_full, exp_busy, exp_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Words accepted before cycle c and not yet popped (pop happens the cycle before start).
    function automatic int model_count(input int c);
        int n = 0;
        for (int i = 0; i < m_start.size(); i++)
            if (m_acc[i] < c && m_start[i] > c) n++;
        return n;
    endfunction

    function automatic bit model_active(input int c);
        for (int i = 0; i < m_start.size(); i++)
            if (c >= m_start[i] && c < m_start[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_serial(input int c);
        int b;
        logic [DW-1:0] w;
        for (int i = 0; i < m_start.size(); i++) begin
            if (c >= m_start[i] && c < m_start[i] + FRAME) begin
                b = (c - m_start[i]) / CPB;
                w = m_word[i];
                if (b == 0) return 1'b0;
                if (b == DW + 1) return 1'b1;
                return w[b-1];
            end
        end
        return 1'b1;
    endfunction

    // Apply the clock edge that ended cycle c with the inputs that were driven then.
    task automatic apply_edge(input int c);
        int s;
        if (reset) begin
            m_acc.delete(); m_start.delete(); m_word.delete(); sb_q.delete();
            t_free = 0;
        end else if (wr_enable && model_count(c) < DEPTH) begin
            s = (c + 2 > t_free) ? c + 2 : t_free;
            m_acc.push_back(c); m_start.push_back(s); m_word.push_back(data_in);
            t_free = s + FRAME;
            sb_q.push_back(data_in);
        end
        while (m_start.size() > 0 && m_start[0] + FRAME <= c) begin
            void'(m_acc.pop_front()); void'(m_start.pop_front()); void'(m_word.pop_front());
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [DW-1:0] d);
        int n;
        @(posedge clk);
        #1;
        apply_edge(cyc);
        cyc++;
        chk_en    = 1'b1;
        reset     = r;
        wr_enable = w;
        data_in   = d;
        n = model_count(cyc);
        exp_full   = (n == DEPTH);
        exp_ovf    = w && !r && (n == DEPTH);
        exp_busy   = (n != 0) || model_active(cyc);
        exp_serial = model_serial(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    // Cycle-level output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("serial_out", {31'd0, serial_out}, {31'd0, exp_serial});
                check("full", {31'd0, full}, {31'd0, exp_full});
                check("busy", {31'd0, busy}, {31'd0, exp_busy});
                check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
            end
        end
    end

    // Frame receiver: decodes mid-bit samples and pops the word scoreboard
    bit            rx_on = 1'b0;
    int            rx_t = 0;
    logic          rx_start = 1'b1;
    logic [DW-1:0] rx_word = '0;
    initial begin
        int b;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (reset) begin
                    rx_on = 1'b0;
                end else if (!rx_on) begin
                    if (serial_out == 1'b0) begin
                        rx_on = 1'b1;
                        rx_t  = 0;
                    end
                end else begin
                    rx_t++;
                end
                if (rx_on && !reset) begin
                    if (rx_t % CPB == CPB / 2) begin
                        b = rx_t / CPB;
                        if (b == 0) rx_start = serial_out;
                        else if (b <= DW) rx_word[b-1] = serial_out;
                        else begin
                            check("frame_bits", {30'd0, rx_start, serial_out}, 32'd1);
                            if (sb_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
                            else check("frame_word", {24'd0, rx_word}, {24'd0, sb_q.pop_front()});
                        end
                    end
                    if (rx_t == FRAME - 1) rx_on = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [7:0] burst[3];
        burst[0] = 8'h01; burst[1] = 8'h80; burst[2] = 8'hFF;
        // Reset and quiet line
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        idle(20);
        // Single frame
        step(1'b0, 1'b1, 8'hA5);
        idle(45);
        // Three back-to-back frames
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, burst[i]);
        idle(130);
        // Six writes: the sixth overflows
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
        idle(220);
        // Reset during data bit 3 with words queued
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hC3 + i));
        idle(16);
        step(1'b1, 1'b0, 8'h00);
        idle(60);
        // Write while full on the stop-to-start pop cycle
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h50 + i));
        idle(36);
        step(1'b0, 1'b1, 8'h3C);
        idle(220);
        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) step(1'b1, 1'($urandom), 8'($urandom));
            else step(1'b0, ($urandom_range(0, 4) == 0), 8'($urandom));
        end
        idle(300);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        check("receiver_idle", {31'd0, rx_on}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
